// File: rtl/bcd_counter_pkg.sv
// Shared BCD digit types and helpers for the multi-digit up/down counter.
package bcd_counter_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Forces any non-decimal nibble to zero so the count never holds an illegal digit.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t digit);
    return (digit > BCD_MAX) ? bcd_digit_t'(0) : digit;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit cell: steps the digit when enabled and
// raises co when the step wraps (9 -> 0 going up, 0 -> 9 going down).
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       dir_i,
  input  logic       en_i,
  output bcd_digit_t next_o,
  output logic       co_o
);

  logic at_edge;

  assign at_edge = dir_i ? (digit_i == bcd_digit_t'(0)) : (digit_i == BCD_MAX);
  assign co_o    = en_i & at_edge;

  always_comb begin
    next_o = digit_i;
    if (en_i) begin
      if (at_edge) begin
        next_o = dir_i ? BCD_MAX : bcd_digit_t'(0);
      end else begin
        next_o = dir_i ? (digit_i - bcd_digit_t'(1)) : (digit_i + bcd_digit_t'(1));
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, registered terminal count
// and zero flag. Define BCD_COUNTER_SAT_EN to saturate at the range limits instead of wrapping.
module bcd_updown_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                stop,
  input  logic                toggle,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                at_zero
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                tc_q, tc_d;
  logic [4*DIGITS-1:0] stepped;
  logic [4*DIGITS-1:0] sanitized;
  logic [DIGITS:0]     chain;
  logic                step;
  logic                boundary;

  // Digit 0 always sees a carry-in; the result is only used on a step.
  assign chain[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .digit_i (count_q[g*BCD_W +: BCD_W]),
      .dir_i   (toggle),
      .en_i    (chain[g]),
      .next_o  (stepped[g*BCD_W +: BCD_W]),
      .co_o    (chain[g+1])
    );
    assign sanitized[g*BCD_W +: BCD_W] = bcd_sanitize(load_val[g*BCD_W +: BCD_W]);
  end

  assign step     = ~clr & ~load & ~stop;
  assign boundary = chain[DIGITS] & step;

  always_comb begin
    count_d = count_q;
    tc_d    = tc_q;
    if (load) begin
      count_d = sanitized;
      tc_d    = 1'b0;
    end else if (step) begin
      tc_d = boundary;
      if (boundary) begin
`ifdef BCD_COUNTER_SAT_EN
        count_d = count_q;
`else
        count_d = stepped;
`endif
      end else begin
        count_d = stepped;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: a 2-digit and a 3-digit instance share
// stimulus and are checked against an integer-valued reference model.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        clr, stop, toggle, load;
  logic [11:0] load_val3;
  logic [7:0]  load_val2;
  logic [7:0]  count2;
  logic [11:0] count3;
  logic        tc2, tc3, az2, az3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  c2;
    logic        t2;
    logic        z2;
    logic [11:0] c3;
    logic        t3;
    logic        z3;
  } exp_t;

  exp_t sb_q[$];

  int v2 = 0, v3 = 0;
  bit mt2 = 0, mt3 = 0;

  always #5 clk = ~clk;

  assign load_val2 = load_val3[7:0];

  bcd_updown_counter #(.DIGITS(2)) dut2 (
    .clk(clk), .clr(clr), .stop(stop), .toggle(toggle), .load(load),
    .load_val(load_val2), .count(count2), .tc(tc2), .at_zero(az2)
  );

  bcd_updown_counter #(.DIGITS(3)) dut3 (
    .clk(clk), .clr(clr), .stop(stop), .toggle(toggle), .load(load),
    .load_val(load_val3), .count(count3), .tc(tc3), .at_zero(az3)
  );

  function automatic int p10(input int d);
    int r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic int load_value(input logic [31:0] lv, input int d);
    int r = 0;
    for (int i = 0; i < d; i++) begin
      int dig = int'((lv >> (4 * i)) & 32'hF);
      if (dig <= 9) r = r + dig * p10(i);
    end
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  // Model of one counter: value held as a plain integer in 0 .. 10^d-1.
  task automatic model(inout int v, inout bit t, input int d,
                       input bit c, input bit l, input bit s, input bit dn,
                       input logic [31:0] lv);
    int mx = p10(d) - 1;
    if (c) begin
      v = 0; t = 0;
    end else if (l) begin
      v = load_value(lv, d); t = 0;
    end else if (!s) begin
      if (!dn) begin
        if (v == mx) begin
          t = 1;
`ifndef BCD_COUNTER_SAT_EN
          v = 0;
`endif
        end else begin
          v = v + 1; t = 0;
        end
      end else begin
        if (v == 0) begin
          t = 1;
`ifndef BCD_COUNTER_SAT_EN
          v = mx;
`endif
        end else begin
          v = v - 1; t = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit c, input bit l, input bit s, input bit dn,
                     input logic [11:0] lv);
    exp_t e;
    logic [31:0] b2, b3;
    @(negedge clk);
    clr = c; load = l; stop = s; toggle = dn; load_val3 = lv;
    model(v2, mt2, 2, c, l, s, dn, {20'h0, lv});
    model(v3, mt3, 3, c, l, s, dn, {20'h0, lv});
    b2 = to_bcd(v2, 2);
    b3 = to_bcd(v3, 3);
    e.c2 = b2[7:0];  e.t2 = mt2; e.z2 = (v2 == 0);
    e.c3 = b3[11:0]; e.t3 = mt3; e.z3 = (v3 == 0);
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every edge produces one output state to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("count2",   {24'h0, count2}, {24'h0, e.c2});
        chk("tc2",      {31'h0, tc2},    {31'h0, e.t2});
        chk("at_zero2", {31'h0, az2},    {31'h0, e.z2});
        chk("count3",   {20'h0, count3}, {20'h0, e.c3});
        chk("tc3",      {31'h0, tc3},    {31'h0, e.t3});
        chk("at_zero3", {31'h0, az3},    {31'h0, e.z3});
      end
    end
  end

  initial begin
    logic [11:0] lv;
    int r;
    clr = 1'b1; load = 1'b0; stop = 1'b0; toggle = 1'b0; load_val3 = '0;

    // reset, then first up step
    cyc(1, 0, 0, 0, 12'h000);
    cyc(1, 0, 0, 0, 12'h000);
    cyc(0, 0, 0, 0, 12'h000);
    // up rollover
    cyc(0, 1, 0, 0, 12'h098);
    cyc(0, 0, 0, 0, 12'h000);
    cyc(0, 0, 0, 0, 12'h000);
    cyc(0, 0, 0, 0, 12'h000);
    // down rollover
    cyc(0, 1, 0, 1, 12'h001);
    cyc(0, 0, 0, 1, 12'h000);
    cyc(0, 0, 0, 1, 12'h000);
    cyc(0, 0, 0, 1, 12'h000);
    // sanitising and priority
    cyc(0, 1, 0, 0, 12'hAA7);
    cyc(0, 1, 1, 0, 12'h123);
    cyc(1, 1, 0, 0, 12'h456);
    // stop and direction change from 45
    cyc(0, 1, 0, 0, 12'h045);
    cyc(0, 0, 0, 0, 12'h000);
    cyc(0, 0, 1, 0, 12'h000);
    cyc(0, 0, 1, 1, 12'h000);
    cyc(0, 0, 1, 0, 12'h000);
    cyc(0, 0, 0, 1, 12'h000);
    cyc(0, 0, 0, 1, 12'h000);
    // stop held across a boundary, then the step
    cyc(0, 1, 0, 0, 12'h999);
    cyc(0, 0, 1, 0, 12'h000);
    cyc(0, 0, 1, 0, 12'h000);
    cyc(0, 0, 0, 0, 12'h000);
    cyc(0, 0, 0, 0, 12'h000);
    // clr mid-boundary drops tc
    cyc(0, 1, 0, 0, 12'h999);
    cyc(1, 0, 0, 0, 12'h000);
    cyc(0, 0, 0, 1, 12'h000);
    cyc(0, 0, 0, 1, 12'h000);

    // randomized traffic biased toward the range limits
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0: lv = 12'h999;
        1: lv = 12'h000;
        2: lv = 12'h998;
        default: lv = 12'($urandom);
      endcase
      cyc(r < 2, (r >= 2) && (r < 12), $urandom_range(0, 4) == 0,
          1'($urandom_range(0, 1)), lv);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
